ram_dual_clk_init: RTL and testbench
====================================

// Module: ram_dual_clk_init
// PURPOSE
//  Dual-clock simple-dual-port RAM (write port on w_clk, read port on r_clk) with byte enables,
//  selectable read latency and a sequential clear engine replacing per-entry async reset.
//  Memory array carries no reset, so it maps onto block RAM. After reset or init_req the engine
//  writes INIT_VALUE to every address, one per w_clk. Used as storage under async FIFOs and buffers.
// PARAMETERS
//  ADDR_WIDTH    10   address bits; DEPTH = 1<<ADDR_WIDTH
//  DATA_WIDTH    32   data bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
//  READ_LATENCY  1    1 or 2 r_clk cycles from accepted r_en to r_valid/r_data
//  INIT_VALUE    0    DATA_WIDTH-bit word written to every entry by the clear engine
// PORTS
//  w_clk      in   1           write-domain clock; clear engine runs on it
//  r_clk      in   1           read-domain clock
//  rst_n      in   1           reset, asynchronous, active-low (both domains)
//  init_req   in   1           w_clk: pulse to re-clear the whole array
//  init_done  out  1           w_clk: 1 = clear complete, writes accepted
//  w_en       in   1           w_clk: write strobe
//  w_be       in   NB          w_clk: byte enables; bit i covers data[8i+7:8i]
//  w_addr     in   ADDR_WIDTH  w_clk: write address
//  w_data     in   DATA_WIDTH  w_clk: write data
//  r_ready    out  1           r_clk: init_done synchronised to r_clk (2 flops)
//  r_en       in   1           r_clk: read strobe
//  r_addr     in   ADDR_WIDTH  r_clk: read address
//  r_data     out  DATA_WIDTH  r_clk: read data, valid when r_valid=1
//  r_valid    out  1           r_clk: r_data qualifier
//  r_par_err  out  1           r_clk: parity mismatch on returned word (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, any time, incl. mid-clear or mid-read): FSM->CLEAR, cnt=0, init_done=0,
//   r_ready=0, r_valid=0, r_data=0, r_par_err=0, read pipeline flushed. Array contents untouched.
//  FSM (w_clk): CLEAR: mem[cnt]<=INIT_VALUE (all bytes), cnt++; at cnt==DEPTH-1 go IDLE, cnt=0.
//   IDLE: init_done=1; init_req=1 -> CLEAR, init_done=0 from next edge.
//   Clear takes exactly DEPTH cycles; init_done rises on the edge that writes the last entry.
//   init_req during CLEAR ignored (no restart). cnt wraps only via the DEPTH-1 terminal check.
//  Write: accepted when init_done=1 && w_en; bytes with w_be[i]=1 updated, others retained.
//   w_en while init_done=0 dropped silently (not queued). w_be=0 with w_en: no change.
//  Read: accepted when r_ready=1 && r_en; r_en while r_ready=0 ignored, r_valid stays 0.
//   LAT=1: r_data/r_valid registered on the edge after acceptance.
//   LAT=2: extra output register stage; r_valid asserted 2 edges after acceptance.
//   Back-to-back reads: one result per cycle, in order. r_data holds last value when r_valid=0.
//  Collision: same-address read and write in the same interval (async clocks) return either old
//   or new word, never a byte mix required; bench must not check that data.
//  r_ready lags init_done by 2-3 r_clk; on init_req falls 2-3 r_clk after init_done falls.
//   Reads accepted in that window may return pre-clear data; users wait for r_ready re-rise.
// CONFIGURATION
//  RAM_PARITY_EN defined: one even-parity bit per byte stored alongside data (array width
//   DATA_WIDTH+NB); computed on write and on clear; on read recomputed, r_par_err=1 in the same
//   cycle as r_valid if any lane mismatches; r_par_err=0 whenever r_valid=0.
//  RAM_PARITY_EN undefined: no parity storage; r_par_err tied to 0.
// TESTING (ADDR_WIDTH=4, DATA_WIDTH=32, INIT_VALUE=32'hA5A5_A5A5 unless stated)
//  1 release rst_n -> init_done=1 exactly 16 w_clk later; read all 16 addrs -> 32'hA5A5A5A5, r_valid each.
//  2 write 32'h1122_3344 @3 be=4'hF, then 32'hFFFF_FFFF @3 be=4'b0101 -> read @3 = 32'h11FF_33FF.
//  3 w_en @5 during clear (cycle 2) -> after clear read @5 = 32'hA5A5A5A5; r_en before r_ready -> no r_valid.
//  4 READ_LATENCY=2, r_en @0..3 back-to-back -> r_valid high 4 cycles starting 2 edges after first r_en,
//    data in address order; repeat with LAT=1 -> 1 edge.
//  5 rst_n low at cnt=7 mid-clear, then high -> clear restarts at 0, init_done after 16 cycles;
//    init_req in IDLE -> init_done low next edge, high 16 cycles later, all words re-cleared.
//  6 RAM_PARITY_EN: force-flip one stored bit @9 via hierarchical deposit -> read @9 gives r_par_err=1
//    with r_valid; unflipped addr -> 0; without macro r_par_err always 0.

Source files
------------

// File: rtl/ram_dual_clk_init.sv
// Dual-clock simple-dual-port RAM with byte enables, 1/2-cycle read latency and a sequential clear engine.
// Optional per-byte even parity storage and checking is enabled by defining RAM_PARITY_EN.
module ram_dual_clk_init #(
    parameter int                    ADDR_WIDTH   = 10,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                    w_clk,
    input  logic                    r_clk,
    input  logic                    rst_n,
    input  logic                    init_req,
    output logic                    init_done,
    input  logic                    w_en,
    input  logic [DATA_WIDTH/8-1:0] w_be,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic                    r_ready,
    input  logic                    r_en,
    input  logic [ADDR_WIDTH-1:0]   r_addr,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_valid,
    output logic                    r_par_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;
`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_WIDTH + NB;
`else
    localparam int MEM_W = DATA_WIDTH;
`endif

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nx;

    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_CLEAR: begin
                cnt_nx = cnt + ADDR_WIDTH'(1);
                if (cnt == '1) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            end
            ST_IDLE:  if (init_req) state_nx = ST_CLEAR;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    assign init_done = (state == ST_IDLE);

    // Single write port shared by the clear engine and user writes.
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [NB-1:0]         wr_lane;

    always_comb begin
        wr_addr = w_addr;
        wr_word = w_data;
        wr_lane = (init_done && w_en) ? w_be : '0;
        if (state == ST_CLEAR) begin
            wr_addr = cnt;
            wr_word = INIT_VALUE;
            wr_lane = '1;
        end
    end

    // NOTE: the array deliberately has no reset so it maps onto block RAM; the clear engine initialises it.
    logic [MEM_W-1:0] mem [DEPTH];

    always_ff @(posedge w_clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lane[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_word[8*i +: 8];
`ifdef RAM_PARITY_EN
                mem[wr_addr][DATA_WIDTH+i] <= ^wr_word[8*i +: 8];
`endif
            end
        end
    end

    logic [1:0] rdy_sync;

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) rdy_sync <= '0;
        else        rdy_sync <= {rdy_sync[0], init_done};
    end

    assign r_ready = rdy_sync[1];

    logic             rd_acc;
    logic [MEM_W-1:0] out_q;
    logic             out_v;

    assign rd_acc = r_ready && r_en;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [MEM_W-1:0] pipe_q;
            logic             pipe_v;

            always_ff @(posedge r_clk) begin
                if (rd_acc) pipe_q <= mem[r_addr];
            end

            always_ff @(posedge r_clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_v <= 1'b0;
                    out_v  <= 1'b0;
                    out_q  <= '0;
                end else begin
                    pipe_v <= rd_acc;
                    out_v  <= pipe_v;
                    if (pipe_v) out_q <= pipe_q;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge r_clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_v <= 1'b0;
                    out_q <= '0;
                end else begin
                    out_v <= rd_acc;
                    if (rd_acc) out_q <= mem[r_addr];
                end
            end
        end
    endgenerate

    assign r_data  = out_q[DATA_WIDTH-1:0];
    assign r_valid = out_v;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_bad;

    always_comb begin
        par_bad = '0;
        for (int i = 0; i < NB; i++) begin
            par_bad[i] = (^out_q[8*i +: 8]) ^ out_q[DATA_WIDTH+i];
        end
    end

    assign r_par_err = out_v && (|par_bad);
`else
    assign r_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_dual_clk_init.sv
// Scoreboard bench for ram_dual_clk_init: one LAT=1 and one LAT=2 instance share all stimulus.
// Parity corruption checks are compiled in only when RAM_PARITY_EN is defined.
module tb_ram_dual_clk_init;

    localparam logic [31:0] INIT = 32'hA5A5_A5A5;

    logic        w_clk = 1'b0;
    logic        r_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_req = 1'b0;
    logic        w_en = 1'b0;
    logic [3:0]  w_be = '0;
    logic [3:0]  w_addr = '0;
    logic [31:0] w_data = '0;
    logic        r_en = 1'b0;
    logic [3:0]  r_addr = '0;

    logic        init_done1, init_done2, r_ready1, r_ready2;
    logic        r_valid1, r_valid2, r_par_err1, r_par_err2;
    logic [31:0] r_data1, r_data2;

    always #5 w_clk = ~w_clk;
    always #7 r_clk = ~r_clk;

    ram_dual_clk_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .INIT_VALUE(INIT)) dut1 (
        .w_clk(w_clk), .r_clk(r_clk), .rst_n(rst_n), .init_req(init_req), .init_done(init_done1),
        .w_en(w_en), .w_be(w_be), .w_addr(w_addr), .w_data(w_data), .r_ready(r_ready1),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data1), .r_valid(r_valid1), .r_par_err(r_par_err1)
    );

    ram_dual_clk_init #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .INIT_VALUE(INIT)) dut2 (
        .w_clk(w_clk), .r_clk(r_clk), .rst_n(rst_n), .init_req(init_req), .init_done(init_done2),
        .w_en(w_en), .w_be(w_be), .w_addr(w_addr), .w_data(w_data), .r_ready(r_ready2),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data2), .r_valid(r_valid2), .r_par_err(r_par_err2)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        logic        perr;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1, e2;
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rcyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge r_clk) rcyc <= rcyc + 1;

    // Monitors: pop one expectation per presented word and check data, arrival cycle and parity flag.
    always @(negedge r_clk) begin
        if (!rst_n) last1 = '0;
        if (r_valid1) begin
            if (q1.size() == 0) check("lat1_unexpected_valid", 1, 0);
            else begin
                e1 = q1.pop_front();
                check("lat1_data", r_data1, e1.data);
                check("lat1_cycle", rcyc, e1.due);
                check("lat1_par", r_par_err1, e1.perr);
                last1 = e1.data;
            end
        end else begin
            check("lat1_hold", r_data1, last1);
            check("lat1_par_idle", r_par_err1, 0);
        end
    end

    always @(negedge r_clk) begin
        if (!rst_n) last2 = '0;
        if (r_valid2) begin
            if (q2.size() == 0) check("lat2_unexpected_valid", 1, 0);
            else begin
                e2 = q2.pop_front();
                check("lat2_data", r_data2, e2.data);
                check("lat2_cycle", rcyc, e2.due);
                check("lat2_par", r_par_err2, e2.perr);
                last2 = e2.data;
            end
        end else begin
            check("lat2_hold", r_data2, last2);
            check("lat2_par_idle", r_par_err2, 0);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge w_clk);
        w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
        @(negedge w_clk);
        w_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] d, input logic p);
        @(negedge r_clk);
        if (!(r_ready1 && r_ready2)) check("rd_while_not_ready", {r_ready1, r_ready2}, 2'b11);
        r_en = 1'b1; r_addr = a;
        q1.push_back('{data: d, due: rcyc + 1, perr: p});
        q2.push_back('{data: d, due: rcyc + 2, perr: p});
    endtask

    task automatic rd_stop();
        @(negedge r_clk);
        r_en = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(r_ready1 && r_ready2) && n < 40) begin
            @(negedge r_clk);
            n++;
        end
        check("r_ready_rise_timeout", n < 40, 1);
    endtask

    // Counts w_clk edges until init_done, starting from the caller's current point.
    task automatic count_done(input string name, input int exp_n);
        int n = 0;
        do begin
            @(posedge w_clk);
            #1;
            n++;
        end while (!init_done1 && n < 100);
        check(name, n, exp_n);
        check("init_done2_match", init_done2, 1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_init_done"}, {init_done1, init_done2}, 0);
        check({name, "_r_ready"}, {r_ready1, r_ready2}, 0);
        check({name, "_r_valid"}, {r_valid1, r_valid2}, 0);
        check({name, "_r_data"}, {r_data1, r_data2}, 0);
        check({name, "_r_par_err"}, {r_par_err1, r_par_err2}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #33;
        check_reset_state("reset");

        // Initial clear, with a dropped write and early reads while the array is clearing.
        @(negedge w_clk);
        rst_n = 1'b1;
        fork
            count_done("first_clear_len", 16);
            begin
                @(negedge w_clk);
                @(negedge w_clk);
                w_en = 1'b1; w_addr = 4'd5; w_data = 32'hDEAD_BEEF; w_be = 4'hF;
                @(negedge w_clk);
                w_en = 1'b0;
            end
            begin
                repeat (3) begin
                    @(negedge r_clk);
                    r_en = 1'b1; r_addr = 4'd5;
                    check("early_r_ready", r_ready1, 0);
                    check("early_r_valid", r_valid1, 0);
                end
                @(negedge r_clk);
                r_en = 1'b0;
            end
        join
        wait_ready();
        for (int i = 0; i < 16; i++) rd(4'(i), INIT, 1'b0);
        rd_stop();

        // Byte enables, zero-enable write and a back-to-back burst.
        wr(4'd3, 32'h1122_3344, 4'hF);
        wr(4'd3, 32'hFFFF_FFFF, 4'b0101);
        wr(4'd4, 32'h0000_0000, 4'h0);
        wr(4'd0, 32'h0000_0001, 4'hF);
        wr(4'd1, 32'h1234_5678, 4'hF);
        wr(4'd2, 32'hCAFE_F00D, 4'b1100);
        rd(4'd0, 32'h0000_0001, 1'b0);
        rd(4'd1, 32'h1234_5678, 1'b0);
        rd(4'd2, 32'hCAFE_A5A5, 1'b0);
        rd(4'd3, 32'h11FF_33FF, 1'b0);
        rd(4'd4, INIT, 1'b0);
        rd(4'd5, INIT, 1'b0);
        rd_stop();
        repeat (5) @(negedge r_clk);

        // Re-clear via init_req; a second request mid-clear must not restart it.
        @(negedge w_clk);
        init_req = 1'b1;
        @(posedge w_clk);
        #1;
        check("init_req_drops_done", {init_done1, init_done2}, 0);
        init_req = 1'b0;
        fork
            count_done("reclear_len", 16);
            begin
                repeat (4) @(negedge w_clk);
                init_req = 1'b1;
                @(negedge w_clk);
                init_req = 1'b0;
            end
        join
        wait_ready();
        for (int i = 0; i < 16; i++) rd(4'(i), INIT, 1'b0);
        rd_stop();
        repeat (5) @(negedge r_clk);

        // Reset asserted mid-clear restarts the clear from address 0.
        wr(4'd7, 32'h7777_7777, 4'hF);
        @(negedge w_clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("reset2");
        @(negedge w_clk);
        rst_n = 1'b1;
        repeat (7) @(posedge w_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("midclear_reset");
        @(negedge w_clk);
        rst_n = 1'b1;
        count_done("restart_clear_len", 16);
        wait_ready();
        rd(4'd7, INIT, 1'b0);
        rd(4'd15, INIT, 1'b0);
        rd_stop();
        repeat (5) @(negedge r_clk);

`ifdef RAM_PARITY_EN
        dut1.mem[9][0] = ~dut1.mem[9][0];
        dut2.mem[9][0] = ~dut2.mem[9][0];
        rd(4'd9, 32'hA5A5_A5A4, 1'b1);
        rd(4'd8, INIT, 1'b0);
        rd_stop();
`else
        rd(4'd9, INIT, 1'b0);
        rd(4'd8, INIT, 1'b0);
        rd_stop();
`endif

        repeat (6) @(negedge r_clk);
        check("lat1_queue_drained", q1.size(), 0);
        check("lat2_queue_drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
